// File: rtl/median_pkg.sv
// Median driver shared types and constants.
// Window geometry and FSM encoding live here.
package median_pkg;

  localparam int WIN   = 9;
  localparam int IDX_W = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEND,
    ST_WAIT,
    ST_HOLD
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic is_last(input idx_t i);
    return i == idx_t'(WIN - 1);
  endfunction

endpackage

// File: rtl/median_driver_win_buf.sv
// 3x3 window store: one write port, one read port.
// Entries are addressed in arrival order, 0..WIN-1.
module median_driver_win_buf
  import median_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_we,
  input  idx_t             i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  idx_t             i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [WIN];
  logic [WIDTH-1:0] w_rdata;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < WIN; i++)
        r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < WIN; i++)
        if (i_we && i_waddr == idx_t'(i))
          r_mem[i] <= i_wdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < WIN; i++)
      if (i_raddr == idx_t'(i))
        w_rdata = r_mem[i];
  end

  assign o_rdata = w_rdata;

endmodule

// File: rtl/median_driver.sv
// Feeds 3x3 windows to an external median filter
// and captures its result with a WAIT timeout.
module median_driver
  import median_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [WIDTH-1:0] DI,
  output logic             DSI,
  input  logic [WIDTH-1:0] DO,
  input  logic             DSO,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             ERR,
  input  logic             CLR_ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  idx_t             r_cnt;
  idx_t             r_idx;
  logic [TW-1:0]    r_wcnt;
  logic [WIDTH-1:0] r_res;
  logic             r_res_valid;
  logic             r_err;

  logic             w_ready;
  logic             w_accept;
  logic             w_tmo;
  logic             w_send;
  logic [WIDTH-1:0] w_rdata;

  assign w_send   = (r_state == ST_SEND);
  assign w_ready  = (r_cnt < idx_t'(WIN)) && !w_send;
  assign w_accept = PIX_VALID && w_ready;
  // A DSO on the final WAIT cycle wins over the timeout.
  assign w_tmo    = (r_state == ST_WAIT) && !DSO &&
                    (r_wcnt == TW'(TIMEOUT));

  median_driver_win_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_we    (w_accept),
    .i_waddr (r_cnt),
    .i_wdata (PIX_IN),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_FILL;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept)
        r_cnt <= r_cnt + 1'b1;

      if (w_tmo)
        r_err <= 1'b1;
      else if (CLR_ERR)
        r_err <= 1'b0;

      unique case (r_state)
        ST_FILL: begin
          if (r_cnt == idx_t'(WIN) ||
              (w_accept && r_cnt == idx_t'(WIN - 1))) begin
            r_state <= ST_SEND;
            r_idx   <= '0;
          end
        end
        ST_SEND: begin
          if (is_last(r_idx)) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_WAIT: begin
          if (DSO) begin
            r_res       <= DO;
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else if (w_tmo) begin
            r_state <= ST_FILL;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // Strobe decodes straight from state so reset kills it at once.
  assign DSI       = w_send;
  assign DI        = w_send ? w_rdata : '0;
  assign PIX_READY = w_ready;
  assign RES       = r_res;
  assign RES_VALID = r_res_valid;
  assign ERR       = r_err;

endmodule

// File: tb/tb_median_driver.sv
// Directed bench for median_driver.
// Expected values are hand-computed constants.
module tb_median_driver;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] PIX_IN;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic [7:0] DI;
  logic       DSI;
  logic [7:0] DO;
  logic       DSO;
  logic [7:0] RES;
  logic       RES_VALID;
  logic       RES_READY;
  logic       ERR;
  logic       CLR_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] win [5][9];

  always #5 CLK = ~CLK;

  median_driver #(
    .WIDTH   (8),
    .TIMEOUT (63)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .PIX_IN    (PIX_IN),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .DI        (DI),
    .DSI       (DSI),
    .DO        (DO),
    .DSO       (DSO),
    .RES       (RES),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .ERR       (ERR),
    .CLR_ERR   (CLR_ERR)
  );

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input int k);
    for (int i = 0; i < 9; i++) begin
      PIX_IN    = win[k][i];
      PIX_VALID = 1'b1;
      expect_eq($sformatf("feed%0d_ready%0d", k, i),
                32'(PIX_READY), 1);
      tick();
    end
    PIX_VALID = 1'b0;
    PIX_IN    = 8'd0;
  endtask

  task automatic send_chk(input int k, input int dso_at);
    for (int j = 0; j < 9; j++) begin
      expect_eq($sformatf("send%0d_dsi%0d", k, j), 32'(DSI), 1);
      expect_eq($sformatf("send%0d_di%0d", k, j),
                32'(DI), 32'(win[k][j]));
      expect_eq($sformatf("send%0d_rdy%0d", k, j),
                32'(PIX_READY), 0);
      DSO = (j == dso_at);
      DO  = 8'hAA;
      tick();
    end
    DSO = 1'b0;
    DO  = 8'd0;
  endtask

  initial begin
    win[0] = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7,
               8'd3, 8'd6, 8'd4, 8'd5};
    win[1] = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24,
               8'd25, 8'd26, 8'd27, 8'd28};
    win[2] = '{8'd30, 8'd31, 8'd32, 8'd33, 8'd34,
               8'd35, 8'd36, 8'd37, 8'd38};
    win[3] = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44,
               8'd45, 8'd46, 8'd47, 8'd48};
    win[4] = '{8'd17, 8'd3, 8'd99, 8'd42, 8'd8,
               8'd250, 8'd64, 8'd1, 8'd33};

    nRST = 1'b0; PIX_IN = 8'd0; PIX_VALID = 1'b0;
    DO = 8'd0; DSO = 1'b0; RES_READY = 1'b0;
    CLR_ERR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    expect_eq("rst_dsi", 32'(DSI), 0);
    expect_eq("rst_di", 32'(DI), 0);
    expect_eq("rst_res", 32'(RES), 0);
    expect_eq("rst_rv", 32'(RES_VALID), 0);
    expect_eq("rst_err", 32'(ERR), 0);
    nRST = 1'b1;
    tick();
    expect_eq("rst_ready", 32'(PIX_READY), 1);

    // Window 0: basic burst and capture
    feed(0);
    send_chk(0, -1);
    expect_eq("w0_wait_dsi", 32'(DSI), 0);
    expect_eq("w0_wait_rdy", 32'(PIX_READY), 1);
    repeat (40) tick();
    expect_eq("w0_pre_rv", 32'(RES_VALID), 0);
    DSO = 1'b1; DO = 8'd5;
    tick();
    DSO = 1'b0; DO = 8'd0;
    expect_eq("w0_rv", 32'(RES_VALID), 1);
    expect_eq("w0_res", 32'(RES), 5);

    // Window 1 arrives while result is held
    feed(1);
    expect_eq("hold_full_rdy", 32'(PIX_READY), 0);
    PIX_VALID = 1'b1; PIX_IN = 8'hEE;
    for (int i = 0; i < 11; i++) begin
      expect_eq("hold_rv", 32'(RES_VALID), 1);
      expect_eq("hold_res", 32'(RES), 5);
      expect_eq("hold_dsi", 32'(DSI), 0);
      tick();
    end
    PIX_VALID = 1'b0; PIX_IN = 8'd0;
    RES_READY = 1'b1; DSO = 1'b1; DO = 8'hAA;
    tick();
    RES_READY = 1'b0;
    expect_eq("rel_rv", 32'(RES_VALID), 0);
    expect_eq("rel_res", 32'(RES), 5);
    expect_eq("rel_dsi", 32'(DSI), 0);
    tick();
    send_chk(1, 3);
    expect_eq("w1_ign_res", 32'(RES), 5);
    expect_eq("w1_ign_rv", 32'(RES_VALID), 0);

    // DSO on the exact timeout cycle is a good result
    repeat (63) tick();
    expect_eq("edge_pre_err", 32'(ERR), 0);
    expect_eq("edge_pre_rv", 32'(RES_VALID), 0);
    DSO = 1'b1; DO = 8'h3C;
    tick();
    DSO = 1'b0; DO = 8'd0;
    expect_eq("edge_res", 32'(RES), 32'h3C);
    expect_eq("edge_rv", 32'(RES_VALID), 1);
    expect_eq("edge_err", 32'(ERR), 0);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    expect_eq("edge_rel_rv", 32'(RES_VALID), 0);

    // Window 2: filter never answers
    feed(2);
    send_chk(2, -1);
    repeat (63) tick();
    expect_eq("tmo_pre_err", 32'(ERR), 0);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    expect_eq("tmo_err", 32'(ERR), 1);
    expect_eq("tmo_rv", 32'(RES_VALID), 0);
    expect_eq("tmo_res", 32'(RES), 32'h3C);
    expect_eq("tmo_rdy", 32'(PIX_READY), 1);
    tick();
    expect_eq("tmo_sticky", 32'(ERR), 1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    expect_eq("clr_err", 32'(ERR), 0);

    // Window 3: reset in the middle of the burst
    feed(3);
    repeat (4) tick();
    expect_eq("mid_dsi", 32'(DSI), 1);
    expect_eq("mid_di", 32'(DI), 32'(win[3][4]));
    #1 nRST = 1'b0;
    #1;
    expect_eq("arst_dsi", 32'(DSI), 0);
    expect_eq("arst_di", 32'(DI), 0);
    expect_eq("arst_res", 32'(RES), 0);
    expect_eq("arst_rv", 32'(RES_VALID), 0);
    expect_eq("arst_err", 32'(ERR), 0);
    #1 nRST = 1'b1;
    tick();

    // Window 4: starts cleanly at entry 0, median 33
    feed(4);
    send_chk(4, -1);
    repeat (5) tick();
    DSO = 1'b1; DO = 8'd33;
    tick();
    DSO = 1'b0; DO = 8'd0;
    expect_eq("w4_res", 32'(RES), 33);
    expect_eq("w4_rv", 32'(RES_VALID), 1);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    expect_eq("w4_rel_rv", 32'(RES_VALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/median_driver.md
MEDIAN_DRIVER -- requirements
Module: median_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel/result bit width.
REQ-002 SHALL have parameter TIMEOUT, default 63, max cycles in WAIT before error.
REQ-003 SHALL have CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have PIX_IN  input  WIDTH  upstream pixel.
REQ-006 SHALL have PIX_VALID  input  1  upstream pixel valid.
REQ-007 SHALL have PIX_READY  output  1  block accepts pixel this cycle.
REQ-008 SHALL have DI  output  WIDTH  pixel to median filter.
REQ-009 SHALL have DSI  output  1  median-filter input strobe.
REQ-010 SHALL have DO  input  WIDTH  median result from filter.
REQ-011 SHALL have DSO  input  1  median result strobe (1-cycle pulse).
REQ-012 SHALL have RES  output  WIDTH  captured median result.
REQ-013 SHALL have RES_VALID  output  1  RES holds an unconsumed result.
REQ-014 SHALL have RES_READY  input  1  downstream consumes RES.
REQ-015 SHALL have ERR  output  1  sticky timeout flag.
REQ-016 SHALL have CLR_ERR  input  1  synchronous clear of ERR.

Function
REQ-017 SHALL buffer one 3x3 window as 9 entries, index 0..8, filled in arrival order; pixel accepted when PIX_VALID and PIX_READY both 1.
REQ-018 SHALL drive PIX_READY=1 iff fill count < 9 and state != SEND.
REQ-019 SHALL implement states FILL, SEND, WAIT, HOLD; FILL->SEND when count=9 (i.e. the cycle after the 9th accept, or immediately in FILL if count already 9).
REQ-020 SHALL in SEND drive DSI=1 for exactly 9 consecutive cycles with DI=buf[0]..buf[8] in order; DSI=0 and DI=0 in all other states.
REQ-021 SHALL clear fill count to 0 on the last SEND cycle and go to WAIT; buffer refills during WAIT/HOLD/FILL.
REQ-022 SHALL in WAIT capture DO into RES on the cycle DSO=1, go to HOLD, RES_VALID=1 next cycle.
REQ-023 SHALL ignore DSO in any state other than WAIT.
REQ-024 SHALL in HOLD keep RES and RES_VALID stable until RES_READY=1; that cycle RES_VALID drops next edge and state goes to FILL.
REQ-025 SHALL never assert DSI before the cycle after the DSO pulse of the previous window (guaranteed by WAIT/HOLD ordering).
REQ-026 SHALL count WAIT cycles with a counter of ceil(log2(TIMEOUT+1)) bits; on reaching TIMEOUT without DSO, set ERR=1, leave RES unchanged, go to FILL without RES_VALID.
REQ-027 SHALL give set priority over CLR_ERR when timeout and CLR_ERR coincide.
REQ-028 SHALL, when DSO arrives on the same cycle the counter reaches TIMEOUT, treat it as a valid result (no ERR).
REQ-029 SHALL produce first DSI cycle exactly 1 cycle after 9th pixel accept; RES_VALID exactly 1 cycle after DSO.

Reset
REQ-030 SHALL on nRST=0: state FILL, count 0, WAIT counter 0, DSI=0, DI=0, RES=0, RES_VALID=0, ERR=0; PIX_READY=1 after release.
REQ-031 SHALL on reset mid-SEND abort the burst immediately (DSI=0 same cycle, asynchronously) and discard buffered pixels.

Structure
REQ-032 SHALL place state enum and window size constant (9) in shared package median_pkg.
REQ-033 SHALL be a single module; no sub-module required (optional window buffer sub-module win_buf).

Verification
REQ-034 Feed 9,1,8,2,7,3,6,4,5 back-to-back; filter model DSO with DO=5 after 41 cycles -> DSI high 9 cycles, DI order as fed, RES=5, RES_VALID 1 cycle after DSO.
REQ-035 Hold RES_READY=0 for 20 cycles while next window 9 pixels arrive -> PIX_READY falls after 9 accepts, RES stable, SEND starts only after RES_READY.
REQ-036 Model never pulses DSO -> ERR=1 after 63 WAIT cycles, no RES_VALID, state FILL; CLR_ERR=1 clears ERR next edge.
REQ-037 Assert nRST=0 at SEND cycle 4 -> DSI=0 immediately, all outputs at reset values, next window starts at buf[0].
REQ-038 Pulse DSO during FILL and SEND -> RES unchanged, no RES_VALID; DSO on cycle counter=TIMEOUT -> RES captured, ERR=0.
REQ-039 Connect to real median filter with 3 consecutive random windows -> each RES equals reference median, DSI never overlaps pending WAIT.
